ahb_burst_master: RTL and testbench

- AHB-Lite master that sits directly upstream of the team's halfword AHB memory slave and drives its HADDR/HTRANS/HBURST/HWDATA bus.
- Accepts one command at a time: address, beat count, direction.
- Issues a SINGLE or INCR burst of halfword transfers using the AHB address/data-phase pipeline.
- Streams write data in from a valid/ready source and read data out as a valid strobe.

---
 rtl/ahb_burst_master.sv | 164 ++++++++++++++++
 tb/tb_ahb_burst_master.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_burst_master.sv
// AHB-Lite burst master: one SINGLE/INCR halfword burst per command, pipelined address/data phases.
// Define AHB_MASTER_LOCK_EN to add the cmd_lock input and drive HMASTLOCK for locked commands.
module ahb_burst_master #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned LEN_WIDTH  = 4,
    parameter int unsigned ADDR_STEP  = 1
) (
    input  logic                  HCLK,
    input  logic                  RESET,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
`ifdef AHB_MASTER_LOCK_EN
    input  logic                  cmd_lock,
`endif
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH-1:0] HADDR,
    output logic [DATA_WIDTH-1:0] HWDATA,
    output logic [2:0]            HBURST,
    output logic [2:0]            HSIZE,
    output logic [1:0]            HTRANS,
    output logic                  HWRITE,
    output logic                  HMASTLOCK,
    input  logic [DATA_WIDTH-1:0] HRDATA,
    input  logic                  HREADY,
    input  logic                  HRESP
);

    localparam logic [1:0] TransIdle   = 2'b00;
    localparam logic [1:0] TransBusy   = 2'b01;
    localparam logic [1:0] TransNonseq = 2'b10;
    localparam logic [1:0] TransSeq    = 2'b11;

    typedef enum logic [1:0] {StIdle, StAddr, StDataLast, StFinish} state_t;

    state_t               state;
    logic [LEN_WIDTH-1:0] beat;
    logic [LEN_WIDTH-1:0] len_q;
    logic                 dphase;   // a data phase is outstanding on the bus
    logic                 err_q;
    logic                 beat_active;
    logic                 accept;

    assign HSIZE = 3'b001;

    // Write beats are only presented while the source has data; otherwise IDLE/BUSY.
    always_comb begin
        beat_active = 1'b0;
        HTRANS      = TransIdle;
        if (state == StAddr) begin
            beat_active = !HWRITE || wr_valid;
            if (beat == '0) begin
                HTRANS = beat_active ? TransNonseq : TransIdle;
            end else begin
                HTRANS = beat_active ? TransSeq : TransBusy;
            end
        end
    end

    assign accept   = beat_active && HREADY;
    assign wr_ready = accept && HWRITE;

    always_ff @(posedge HCLK or posedge RESET) begin
        if (RESET) begin
            state     <= StIdle;
            beat      <= '0;
            len_q     <= '0;
            dphase    <= 1'b0;
            err_q     <= 1'b0;
            cmd_ready <= 1'b1;
            HADDR     <= '0;
            HWDATA    <= '0;
            HBURST    <= 3'b000;
            HWRITE    <= 1'b0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
`ifdef AHB_MASTER_LOCK_EN
            HMASTLOCK <= 1'b0;
`endif
        end else begin
            rd_valid <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;

            if (HREADY) begin
                dphase <= accept;
            end
            if (dphase && HREADY && !HWRITE && !HRESP && !err_q) begin
                rd_valid <= 1'b1;
                rd_data  <= HRDATA;
            end

            unique case (state)
                StIdle: begin
                    if (cmd_valid) begin
                        state     <= StAddr;
                        cmd_ready <= 1'b0;
                        beat      <= '0;
                        len_q     <= cmd_len;
                        err_q     <= 1'b0;
                        HADDR     <= cmd_addr;
                        HWRITE    <= cmd_write;
                        HBURST    <= (cmd_len == '0) ? 3'b000 : 3'b001;
`ifdef AHB_MASTER_LOCK_EN
                        HMASTLOCK <= cmd_lock;
`endif
                    end
                end
                StAddr: begin
                    if (accept) begin
                        if (HWRITE) begin
                            HWDATA <= wr_data;
                        end
                        if (beat == len_q) begin
                            state <= StDataLast;
                        end else begin
                            beat  <= beat + 1'b1;
                            HADDR <= HADDR + ADDR_WIDTH'(ADDR_STEP);
                        end
                    end
                    // An ERROR response cancels every remaining beat.
                    if (dphase && HRESP) begin
                        err_q <= 1'b1;
                        state <= StDataLast;
                    end
                end
                StDataLast: begin
                    if (dphase && HRESP) begin
                        err_q <= 1'b1;
                    end
                    if (HREADY) begin
                        state     <= StFinish;
                        done      <= 1'b1;
                        error     <= err_q || (dphase && HRESP);
`ifdef AHB_MASTER_LOCK_EN
                        HMASTLOCK <= 1'b0;
`endif
                    end
                end
                StFinish: begin
                    state     <= StIdle;
                    cmd_ready <= 1'b1;
                end
                default: state <= StIdle;
            endcase
        end
    end

`ifndef AHB_MASTER_LOCK_EN
    assign HMASTLOCK = 1'b0;
`endif

endmodule

// File: tb/tb_ahb_burst_master.sv
// Randomized bench for ahb_burst_master: a bus-level slave memory plus a per-beat reference model
// of expected transfer types, addresses, strobes and completion timing.
module tb_ahb_burst_master;

    logic        HCLK = 1'b0;
    logic        RESET;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [15:0] cmd_addr;
    logic [3:0]  cmd_len;
    logic [15:0] wr_data, rd_data, HADDR, HWDATA, HRDATA;
    logic        wr_valid, wr_ready, rd_valid, done, error;
    logic [2:0]  HBURST, HSIZE;
    logic [1:0]  HTRANS;
    logic        HWRITE, HMASTLOCK, HREADY, HRESP;
`ifdef AHB_MASTER_LOCK_EN
    logic        cmd_lock;
`endif

    ahb_burst_master #(
        .DATA_WIDTH(16),
        .ADDR_WIDTH(16),
        .LEN_WIDTH (4),
        .ADDR_STEP (1)
    ) dut (
        .HCLK     (HCLK),
        .RESET    (RESET),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr (cmd_addr),
        .cmd_len  (cmd_len),
`ifdef AHB_MASTER_LOCK_EN
        .cmd_lock (cmd_lock),
`endif
        .wr_data  (wr_data),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .done     (done),
        .error    (error),
        .HADDR    (HADDR),
        .HWDATA   (HWDATA),
        .HBURST   (HBURST),
        .HSIZE    (HSIZE),
        .HTRANS   (HTRANS),
        .HWRITE   (HWRITE),
        .HMASTLOCK(HMASTLOCK),
        .HRDATA   (HRDATA),
        .HREADY   (HREADY),
        .HRESP    (HRESP)
    );

    always #5 HCLK = ~HCLK;

    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] mem  [0:65535];
    int          gap  [16];   // idle source cycles before each write beat
    int          ws   [16];   // wait states inserted in each data phase
    logic [15:0] wdat [16];
    logic [15:0] old  [16];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_cfg();
        for (int i = 0; i < 16; i++) begin
            gap[i]  = 0;
            ws[i]   = 0;
            wdat[i] = 16'($urandom);
        end
    endtask

    task automatic run_cmd(input logic [15:0] addr, input int len, input logic wr,
                           input int err_beat, input logic lock);
        int nb, acc, widx, gap_left, strobes, done_due, dp_beat, ws_left, c, exp_beats, good;
        bit aborted, dp_valid, err_phase, rd_pending, wv_hold, fin;
        logic [15:0] dp_addr;
        logic in_addr, act;
        logic [1:0] exp_trans;
        nb = len + 1; acc = 0; widx = 0; strobes = 0; done_due = -1; dp_beat = 0;
        ws_left = 0; c = 0; aborted = 0; dp_valid = 0; err_phase = 0; rd_pending = 0;
        wv_hold = 0; fin = 0; dp_addr = '0;
        gap_left = gap[0];
        for (int i = 0; i < nb; i++) old[i] = mem[16'(addr + i)];
        while (!fin && c < 300) begin
            @(negedge HCLK);
            if (c == 0) begin
                cmd_valid = 1'b1; cmd_addr = addr; cmd_len = 4'(len); cmd_write = wr;
            end else begin
                // Commands offered while busy must be ignored.
                cmd_valid = ($urandom_range(0, 3) == 0);
                cmd_addr  = 16'($urandom); cmd_len = 4'($urandom); cmd_write = 1'($urandom);
            end
`ifdef AHB_MASTER_LOCK_EN
            cmd_lock = (c == 0) ? lock : 1'($urandom);
`endif
            if (dp_valid) begin
                if (dp_beat == err_beat) begin
                    HRESP = 1'b1; HREADY = err_phase;
                end else begin
                    HRESP = 1'b0; HREADY = (ws_left == 0);
                end
                HRDATA = wr ? 16'($urandom) : mem[dp_addr];
            end else begin
                HRESP = 1'b0; HREADY = 1'b1; HRDATA = 16'($urandom);
            end
            if (!wr || c == 0) wr_valid = 1'b0;
            else if (wv_hold) wr_valid = 1'b1;
            else if (widx >= nb) wr_valid = 1'b0;
            else if (gap_left > 0) begin
                wr_valid = 1'b0; gap_left--;
            end else wr_valid = 1'b1;
            if (wr_valid && widx < 16) wr_data = wdat[widx];
            else wr_data = 16'($urandom);
            #1;
            in_addr   = (c >= 1) && (acc < nb) && !aborted;
            act       = in_addr && (!wr || wr_valid);
            exp_trans = act ? ((acc == 0) ? 2'b10 : 2'b11) : ((in_addr && acc > 0) ? 2'b01 : 2'b00);
            check_eq("cmd_ready", cmd_ready, c == 0);
            check_eq("htrans", HTRANS, exp_trans);
            if (in_addr) check_eq("haddr", HADDR, 16'(addr + acc));
            check_eq("wr_ready", wr_ready, wr && act && HREADY);
            check_eq("rd_valid", rd_valid, rd_pending);
            if (rd_valid) begin
                check_eq("rd_data", rd_data, mem[16'(addr + strobes)]);
                strobes++;
            end
            check_eq("done", done, c == done_due);
            if (c >= 1) begin
                check_eq("hburst", HBURST, (len == 0) ? 0 : 1);
                check_eq("hwrite", HWRITE, wr);
            end
            check_eq("hsize", HSIZE, 3'b001);
            check_eq("hmastlock", HMASTLOCK, lock && c >= 1 && c != done_due);
            if (done) begin
                check_eq("error", error, err_beat >= 0);
                fin = 1;
            end
            // What the coming clock edge does on the bus.
            rd_pending = 0;
            if (dp_valid) begin
                if (HRESP) aborted = 1;
                if (HREADY) begin
                    if (!HRESP) begin
                        if (wr) begin
                            check_eq("hwdata", HWDATA, wdat[dp_beat]);
                            mem[dp_addr] = HWDATA;
                        end else rd_pending = 1;
                    end
                    if (HRESP || dp_beat == nb - 1) done_due = c + 1;
                    dp_valid = 0;
                end else if (dp_beat == err_beat) err_phase = 1;
                else ws_left--;
            end
            if (act && HREADY) begin
                dp_valid = 1; dp_beat = acc; dp_addr = HADDR; ws_left = ws[acc]; err_phase = 0;
                acc++;
                if (wr) begin
                    widx++; wv_hold = 0;
                    if (widx < nb) gap_left = gap[widx];
                end
            end else if (wr && wr_valid) wv_hold = 1;
            c++;
        end
        if (!fin) check_eq("timeout", 0, 1);
        cmd_valid = 1'b0;
        wr_valid  = 1'b0;
        exp_beats = (err_beat >= 0) ? err_beat + 1 : nb;
        good      = (err_beat >= 0) ? err_beat : nb;
        check_eq("beats", acc, exp_beats);
        if (!wr) check_eq("rd_count", strobes, good);
        else for (int i = 0; i < nb; i++)
            check_eq("mem", mem[16'(addr + i)], (i < good) ? wdat[i] : old[i]);
    endtask

    task automatic reset_mid_burst();
        @(negedge HCLK);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 16'h0100; cmd_len = 4'd7;
        HREADY = 1'b1; HRESP = 1'b0; wr_valid = 1'b0;
        @(negedge HCLK);
        cmd_valid = 1'b0;
        repeat (2) @(negedge HCLK);
        check_eq("pre_reset_busy", cmd_ready, 0);
        #2 RESET = 1'b1;
        #1;
        check_eq("rst_htrans", HTRANS, 2'b00);
        check_eq("rst_cmd_ready", cmd_ready, 1);
        check_eq("rst_haddr", HADDR, 16'h0000);
        check_eq("rst_done", done, 0);
        check_eq("rst_rd_valid", rd_valid, 0);
        @(negedge HCLK);
        RESET = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge HCLK);
            #1;
            check_eq("post_rst_done", done, 0);
            check_eq("post_rst_htrans", HTRANS, 2'b00);
            check_eq("post_rst_cmd_ready", cmd_ready, 1);
        end
    endtask

    initial begin
        int len, eb;
        logic lk;
        RESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
        wr_data = '0; wr_valid = 1'b1; HRDATA = '0; HREADY = 1'b1; HRESP = 1'b0;
`ifdef AHB_MASTER_LOCK_EN
        cmd_lock = 1'b0;
`endif
        for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
        repeat (2) @(negedge HCLK);
        #1;
        check_eq("reset_htrans", HTRANS, 2'b00);
        check_eq("reset_haddr", HADDR, 16'h0000);
        check_eq("reset_hwdata", HWDATA, 16'h0000);
        check_eq("reset_hburst", HBURST, 3'b000);
        check_eq("reset_hwrite", HWRITE, 0);
        check_eq("reset_hmastlock", HMASTLOCK, 0);
        check_eq("reset_rd", {rd_data, rd_valid}, 17'h0);
        check_eq("reset_done_error", {done, error}, 2'b00);
        check_eq("reset_wr_ready", wr_ready, 0);
        check_eq("reset_cmd_ready", cmd_ready, 1);
        wr_valid = 1'b0;
        RESET = 1'b0;

        clear_cfg(); wdat[0] = 16'hBEEF;
        run_cmd(16'h0014, 0, 1'b1, -1, 1'b0);
        clear_cfg();
        mem[16'h000A] = 16'd110; mem[16'h000B] = 16'd120;
        mem[16'h000C] = 16'd130; mem[16'h000D] = 16'd140;
        run_cmd(16'h000A, 3, 1'b0, -1, 1'b0);
        clear_cfg(); gap[1] = 2;
        run_cmd(16'h0200, 2, 1'b1, -1, 1'b0);
        clear_cfg(); ws[1] = 3;
        run_cmd(16'h0300, 2, 1'b0, -1, 1'b0);
        clear_cfg();
        run_cmd(16'h0400, 3, 1'b1, 1, 1'b0);
        clear_cfg();
        run_cmd(16'hFFFF, 1, 1'b0, -1, 1'b0);
        reset_mid_burst();
        clear_cfg();
        run_cmd(16'h0500, 1, 1'b1, -1, 1'b0);

        for (int n = 0; n < 40; n++) begin
            clear_cfg();
            len = $urandom_range(0, 15);
            eb  = ($urandom_range(0, 5) == 0) ? $urandom_range(0, len) : -1;
            for (int i = 0; i < 16; i++) begin
                if ($urandom_range(0, 3) == 0) gap[i] = $urandom_range(1, 2);
                if ($urandom_range(0, 3) == 0) ws[i]  = $urandom_range(1, 2);
            end
`ifdef AHB_MASTER_LOCK_EN
            lk = 1'($urandom);
`else
            lk = 1'b0;
`endif
            run_cmd(($urandom_range(0, 3) == 0) ? 16'hFFF0 + 16'($urandom_range(0, 15))
                                                : 16'($urandom),
                    len, 1'($urandom), eb, lk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
